// File: rtl/rv32i_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// word geometry and the default load address.
package rv32i_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_BITS      = 8 * BYTES_PER_WORD;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

  // LdChk is only reachable when the checksum trailer is enabled.
  typedef enum logic [2:0] {
    LdLen,
    LdData,
    LdChk,
    LdDone,
    LdErr
  } ld_state_e;

endpackage

// File: rtl/ld_word_asm.sv
// Little-endian byte-to-word assembler. The first byte lands in the least
// significant position. Shared by the length field and the data words.
module ld_word_asm
  import rv32i_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 byte_en,
  input  logic [7:0]           byte_in,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  logic [1:0]           cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;

  // Shift new bytes in from the top; after four bytes the first byte sits at [7:0].
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (byte_en) begin
      shift_d    = {byte_in, shift_q[WORD_BITS-1:8]};
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'd3);
    end
  end

  // Word is presented in the same cycle as its last byte.
  assign word = shift_d;

  // Byte counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Reads a little-endian word count N
// followed by N words from a byte stream, writes them to inst_mem and holds
// the core in reset until the image is complete.
// Optional build macro CHECKSUM_EN: a trailing XOR checksum byte is checked.
module imem_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  ld_state_e        state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             hold_q, hold_d;
  logic             err_q, err_d;
`ifdef CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic                 accept;
  logic                 asm_en;
  logic                 asm_clr;
  logic                 asm_valid;
  logic [WORD_BITS-1:0] asm_word;

  assign accept = in_valid && ready_q;
  assign asm_en = accept && ((state_q == LdLen) || (state_q == LdData));

  ld_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_en    (asm_en),
    .byte_in    (in_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  // Load sequencing: length field, data words, optional checksum, terminal states.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    asm_clr   = 1'b0;
`ifdef CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      LdLen: begin
        if (asm_valid) begin
          n_d = WIDTH'(asm_word);
          if (asm_word == '0) begin
            state_d = LdDone;
            done_d  = 1'b1;
          end else if (asm_word > WORD_BITS'(DEPTH)) begin
            state_d = LdErr;
          end else begin
            state_d = LdData;
            idx_d   = '0;
          end
        end
      end
      LdData: begin
`ifdef CHECKSUM_EN
        if (accept) csum_d = csum_q ^ in_data;
`endif
        if (asm_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = BASE_ADDR + idx_q * WIDTH'(BYTES_PER_WORD);
          wr_data_d = WIDTH'(asm_word);
          idx_d     = idx_q + 1'b1;
          if (idx_q == n_q - 1'b1) begin
`ifdef CHECKSUM_EN
            state_d = LdChk;
`else
            state_d = LdDone;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      LdChk: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = LdDone;
            done_d  = 1'b1;
          end else begin
            state_d = LdErr;
          end
        end
      end
`endif
      LdDone, LdErr: begin
        if (start) begin
          state_d = LdLen;
          n_d     = '0;
          idx_d   = '0;
          asm_clr = 1'b1;
`ifdef CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      default: state_d = LdLen;
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_comb begin
    ready_d = (state_d == LdLen) || (state_d == LdData) || (state_d == LdChk);
    hold_d  = (state_d != LdDone);
    err_d   = (state_d == LdErr);
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LdLen;
      n_q       <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      hold_q    <= 1'b1;
      err_q     <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
`ifdef CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign in_ready = ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized images compared against a
// simple image model (expected writes, done/error outcome).
// Honours the CHECKSUM_EN build macro like the design.
module tb_imem_loader;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks;
  int n_fail;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] img_q[$];
  int          done_cnt;

  imem_loader #(
    .WIDTH     (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write and done pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte when the loader is ready; optionally idle a cycle after.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom_range(0, 255);
      if (gap) @(negedge clk);
    end
  endtask

  // Stream count n and img_q, then compare against the expected outcome.
  task automatic run_load(input logic [31:0] n, input bit gap, input bit bad_csum);
    logic [7:0]  cs;
    logic [31:0] w;
    int          exp_writes;
    bit          exp_ok;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    cs       = 8'h00;
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], gap);
    if (n <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        w = img_q[i];
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8], gap);
          cs ^= w[8*b +: 8];
        end
      end
    end
`ifdef CHECKSUM_EN
    if (n != 0 && n <= DEPTH) send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap);
    exp_ok = (n <= DEPTH) && !(bad_csum && n != 0);
`else
    exp_ok = (n <= DEPTH);
`endif
    repeat (4) @(negedge clk);
    exp_writes = (n <= DEPTH) ? int'(n) : 0;
    check_eq("wr_count", 64'(wa_q.size()), 64'(exp_writes));
    for (int i = 0; i < exp_writes && i < wa_q.size(); i++) begin
      check_eq($sformatf("wr_addr[%0d]", i), 64'(wa_q[i]), 64'(BASE_ADDR + 32'(4 * i)));
      check_eq($sformatf("wr_data[%0d]", i), 64'(wd_q[i]), 64'(img_q[i]));
    end
    check_eq("done_pulses", 64'(done_cnt), exp_ok ? 64'd1 : 64'd0);
    check_eq("error", 64'(error), exp_ok ? 64'd0 : 64'd1);
    check_eq("cpu_hold", 64'(cpu_hold), exp_ok ? 64'd0 : 64'd1);
    check_eq("in_ready_end", 64'(in_ready), 64'd0);
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_eq("restart_error", 64'(error), 64'd0);
    check_eq("restart_hold", 64'(cpu_hold), 64'd1);
    check_eq("restart_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic fill_random(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back($urandom);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'(BASE_ADDR));
    check_eq("rst_wr_data", 64'(wr_data), 64'd0);
    check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two known instructions.
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'h0010_0093);
    run_load(32'd2, 1'b0, 1'b0);
    restart();

    // Empty image.
    img_q.delete();
    run_load(32'd0, 1'b0, 1'b0);
    restart();

    // Oversized image is rejected without writes.
    run_load(32'(DEPTH + 1), 1'b0, 1'b0);
    restart();

    // Sparse valid.
    fill_random(3);
    run_load(32'd3, 1'b1, 1'b0);
    restart();

    // Reset in the middle of the length field.
    wa_q.delete();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_writes", 64'(wa_q.size()), 64'd0);
    check_eq("midrst_hold", 64'(cpu_hold), 64'd1);
    check_eq("midrst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fresh load after the abort must start from a clean byte counter.
    fill_random(1);
    run_load(32'd1, 1'b0, 1'b0);
    restart();

    // Random images.
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      fill_random(n);
      run_load(32'(n), 1'($urandom_range(0, 1)), 1'b0);
      restart();
    end

    // Largest legal image.
    fill_random(DEPTH);
    run_load(32'(DEPTH), 1'b0, 1'b0);
    restart();

`ifdef CHECKSUM_EN
    img_q.delete();
    img_q.push_back(32'hDEAD_BEEF);
    run_load(32'd1, 1'b0, 1'b0);
    restart();
    run_load(32'd1, 1'b0, 1'b1);
    restart();
    fill_random(4);
    run_load(32'd4, 1'b1, 1'b1);
    restart();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
